// File: rtl/rescale_line_buffer_pkg.sv
// Shared defaults, counter width and FSM encoding for the rescaler line buffer.
// need_row() gives the highest source row the rescaler currently depends on.
package rescale_line_buffer_pkg;

    localparam int DEF_PIX_W = 24;
    localparam int DEF_MAX_W = 640;
    localparam int DEF_ROWS  = 4;
    localparam int CNT_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_STALL    = 2'd2,
        ST_COMPLETE = 2'd3
    } lb_state_t;

    // min(wait_row + 1, height - 1), evaluated in CNT_W+1 bits so neither side wraps
    function automatic logic [CNT_W:0] need_row(input logic [CNT_W-1:0] wait_row,
                                                input logic [CNT_W-1:0] height);
        logic [CNT_W:0] next_row;
        logic [CNT_W:0] last_row;
        next_row = {1'b0, wait_row} + (CNT_W+1)'(1);
        last_row = {1'b0, height} - (CNT_W+1)'(1);
        return (next_row < last_row) ? next_row : last_row;
    endfunction

endpackage

// File: rtl/rescale_line_buffer_if.sv
// Source-stream, wait-control and read-port bundle between the line buffer and its users.
// The buffer takes the slave modport; the pixel source / rescaler side takes master.
interface rescale_line_buffer_if import rescale_line_buffer_pkg::*; #(
    parameter int PIX_W = DEF_PIX_W
);
    logic             start;
    logic [CNT_W-1:0] src_w;
    logic [CNT_W-1:0] src_h;
    logic             in_valid;
    logic [PIX_W-1:0] in_data;
    logic             in_ready;
    logic             ld_row_to_wait;
    logic [CNT_W-1:0] row_to_wait;
    logic             buffer_done;
    logic [CNT_W-1:0] rd_row;
    logic [CNT_W-1:0] rd_col;
    logic [PIX_W-1:0] rd_data;
    logic             img_done;

    modport slave (
        input  start, src_w, src_h, in_valid, in_data, ld_row_to_wait, row_to_wait,
               rd_row, rd_col,
        output in_ready, buffer_done, rd_data, img_done
    );

    modport master (
        output start, src_w, src_h, in_valid, in_data, ld_row_to_wait, row_to_wait,
               rd_row, rd_col,
        input  in_ready, buffer_done, rd_data, img_done
    );
endinterface

// File: rtl/rescale_row_ram.sv
// Circular row storage: ROWS slots of MAX_W pixels, one write port, one registered read port.
// Array contents are never reset; only the read register is.
module rescale_row_ram import rescale_line_buffer_pkg::*; #(
    parameter int MAX_W = DEF_MAX_W,
    parameter int ROWS  = DEF_ROWS,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic             clock,
    input  logic             RESETN,
    input  logic             we,
    input  logic [CNT_W-1:0] wr_row,
    input  logic [CNT_W-1:0] wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [CNT_W-1:0] rd_row,
    input  logic [CNT_W-1:0] rd_col,
    output logic [PIX_W-1:0] rd_data
);
    localparam int DEPTH = ROWS * MAX_W;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] SLOT_MASK = CNT_W'(ROWS - 1);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    // ROWS is a power of two, so row mod ROWS is a mask
    assign wr_addr = AW'(wr_row & SLOT_MASK) * AW'(MAX_W) + AW'(wr_col);
    assign rd_addr = AW'(rd_row & SLOT_MASK) * AW'(MAX_W) + AW'(rd_col);

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Separate read register: a same-cycle write to rd_addr lands after the read
    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rescale_line_buffer.sv
// Line buffer feeding a rescaler: streams a raster image into ROWS circular row slots,
// throttling the source so rows the rescaler still needs are never overwritten.
//
//   state       | meaning
//   ST_IDLE     | no image; waiting for start
//   ST_STREAM   | accepting pixels into the current row
//   ST_STALL    | next row would overwrite a row still needed; waiting on wait_reg
//   ST_COMPLETE | all src_w*src_h pixels stored; waiting for start
module rescale_line_buffer import rescale_line_buffer_pkg::*; #(
    parameter int MAX_W = DEF_MAX_W,
    parameter int ROWS  = DEF_ROWS,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic            clock,
    input  logic            RESETN,
    rescale_line_buffer_if.slave bus
);
    localparam logic [CNT_W:0] ROWS_M1 = (CNT_W+1)'(ROWS - 1);

    lb_state_t        state, state_nxt;
    logic [CNT_W-1:0] wr_col, wr_col_nxt;
    logic [CNT_W-1:0] wr_row, wr_row_nxt;
    logic [CNT_W-1:0] src_w_r, src_w_nxt;
    logic [CNT_W-1:0] src_h_r, src_h_nxt;
    logic [CNT_W-1:0] wait_reg, wait_nxt;
    logic             buffer_done_r, buffer_done_nxt;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic [CNT_W:0]   row_inc;
    logic [CNT_W:0]   row_limit;

    assign bus.in_ready    = (state == ST_STREAM);
    assign bus.img_done    = (state == ST_COMPLETE);
    assign bus.buffer_done = buffer_done_r;

    assign accept    = bus.in_valid && (state == ST_STREAM);
    assign last_col  = (wr_col == src_w_r - CNT_W'(1));
    assign last_row  = (wr_row == src_h_r - CNT_W'(1));
    assign row_inc   = {1'b0, wr_row} + (CNT_W+1)'(1);
    assign row_limit = {1'b0, wait_reg} + ROWS_M1;

    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            state         <= ST_IDLE;
            wr_col        <= '0;
            wr_row        <= '0;
            src_w_r       <= '0;
            src_h_r       <= '0;
            wait_reg      <= '0;
            buffer_done_r <= 1'b0;
        end else begin
            state         <= state_nxt;
            wr_col        <= wr_col_nxt;
            wr_row        <= wr_row_nxt;
            src_w_r       <= src_w_nxt;
            src_h_r       <= src_h_nxt;
            wait_reg      <= wait_nxt;
            buffer_done_r <= buffer_done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_col_nxt = wr_col;
        wr_row_nxt = wr_row;
        src_w_nxt  = src_w_r;
        src_h_nxt  = src_h_r;
        wait_nxt   = (bus.ld_row_to_wait && (bus.row_to_wait > wait_reg)) ? bus.row_to_wait
                                                                           : wait_reg;

        unique case (state)
            ST_STREAM: begin
                if (accept) begin
                    if (last_col) begin
                        wr_col_nxt = '0;
                        wr_row_nxt = row_inc[CNT_W-1:0];
                        if (last_row) begin
                            state_nxt = ST_COMPLETE;
                        end else if (row_inc > row_limit) begin
                            state_nxt = ST_STALL;
                        end
                    end else begin
                        wr_col_nxt = wr_col + CNT_W'(1);
                    end
                end
            end
            ST_STALL: begin
                if ({1'b0, wr_row} <= row_limit) begin
                    state_nxt = ST_STREAM;
                end
            end
            default: begin
            end
        endcase

        // start overrides everything, including an image in flight
        if (bus.start) begin
            state_nxt  = ST_STREAM;
            src_w_nxt  = bus.src_w;
            src_h_nxt  = bus.src_h;
            wr_col_nxt = '0;
            wr_row_nxt = '0;
            wait_nxt   = '0;
        end

        // Registered from next-state values so a fresh ld_row_to_wait never shows a stale high
        buffer_done_nxt = (state_nxt == ST_COMPLETE) ||
                          ({1'b0, wr_row_nxt} > need_row(wait_nxt, src_h_nxt));
    end

    rescale_row_ram #(
        .MAX_W (MAX_W),
        .ROWS  (ROWS),
        .PIX_W (PIX_W)
    ) u_row_ram (
        .clock   (clock),
        .RESETN  (RESETN),
        .we      (accept),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (bus.in_data),
        .rd_row  (bus.rd_row),
        .rd_col  (bus.rd_col),
        .rd_data (bus.rd_data)
    );

endmodule

// File: tb/tb_rescale_line_buffer.sv
// Directed-plus-random bench for rescale_line_buffer against an image-level reference model.
module tb_rescale_line_buffer;
    import rescale_line_buffer_pkg::*;

    localparam int MAX_W = 640;
    localparam int ROWS  = 4;
    localparam int PIX_W = 24;

    logic clock  = 1'b0;
    logic RESETN = 1'b0;
    always #5 clock = ~clock;

    rescale_line_buffer_if #(.PIX_W(PIX_W)) bus_if ();

    rescale_line_buffer #(.MAX_W(MAX_W), .ROWS(ROWS), .PIX_W(PIX_W)) dut (
        .clock  (clock),
        .RESETN (RESETN),
        .bus    (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    int dut_acc  = 0;
    bit rd_random = 1'b1;

    // reference model: image-level progress plus a slot-addressed pixel store
    bit               m_active, m_complete, m_started;
    int               m_w, m_h, m_acc, m_wait, m_wait_last;
    logic [PIX_W-1:0] m_mem   [ROWS*MAX_W];
    bit               m_known [ROWS*MAX_W];
    bit               m_rd_known;
    logic [PIX_W-1:0] m_rd_exp;

    function automatic int m_wr_row();
        return (m_w == 0) ? 0 : m_acc / m_w;
    endfunction

    function automatic int addr_of(input int row, input int col);
        return (row % ROWS) * MAX_W + col;
    endfunction

    function automatic bit exp_in_ready();
        return m_active && (m_wr_row() <= m_wait_last + ROWS - 1);
    endfunction

    function automatic bit exp_bd();
        int need;
        if (!m_started) return 1'b0;
        if (m_complete) return 1'b1;
        need = (m_wait + 1 < m_h - 1) ? m_wait + 1 : m_h - 1;
        return m_wr_row() > need;
    endfunction

    task automatic model_reset();
        m_active = 0; m_complete = 0; m_started = 0;
        m_w = 0; m_h = 0; m_acc = 0; m_wait = 0; m_wait_last = 0;
        m_rd_known = 1; m_rd_exp = '0;
    endtask

    task automatic model_edge();
        int ra, wa;
        bit acc;
        ra = addr_of(int'(bus_if.rd_row), int'(bus_if.rd_col));
        m_rd_known = m_known[ra];
        m_rd_exp   = m_mem[ra];
        acc = exp_in_ready() && bus_if.in_valid;
        if (acc) begin
            wa = addr_of(m_wr_row(), m_acc % m_w);
            m_mem[wa]   = bus_if.in_data;
            m_known[wa] = 1'b1;
        end
        m_wait_last = m_wait;
        if (bus_if.start) begin
            m_active = 1; m_complete = 0; m_started = 1;
            m_w = int'(bus_if.src_w); m_h = int'(bus_if.src_h);
            m_acc = 0; m_wait = 0;
        end else begin
            if (acc) begin
                m_acc++;
                if (m_acc == m_w * m_h) begin
                    m_complete = 1; m_active = 0;
                end
            end
            if (bus_if.ld_row_to_wait && int'(bus_if.row_to_wait) > m_wait)
                m_wait = int'(bus_if.row_to_wait);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("in_ready", 32'(bus_if.in_ready), 32'(exp_in_ready()));
        check("buffer_done", 32'(bus_if.buffer_done), 32'(exp_bd()));
        check("img_done", 32'(bus_if.img_done), 32'(m_complete));
        if (m_rd_known) check("rd_data", 32'(bus_if.rd_data), 32'(m_rd_exp));
    endtask

    task automatic cycle();
        if (rd_random) begin
            if ($urandom_range(1) == 0 && m_active) begin
                bus_if.rd_row = 10'(m_wr_row());
                bus_if.rd_col = 10'(m_acc % m_w);
            end else begin
                bus_if.rd_row = 10'($urandom_range(15));
                bus_if.rd_col = 10'($urandom_range(7));
            end
        end
        check_outputs();
        if (bus_if.in_valid && bus_if.in_ready) dut_acc++;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic start_image(input int w, input int h);
        bus_if.start    = 1'b1;
        bus_if.src_w    = 10'(w);
        bus_if.src_h    = 10'(h);
        bus_if.in_valid = 1'b0;
        cycle();
        bus_if.start = 1'b0;
        dut_acc = 0;
    endtask

    // stop when the DUT reports img_done, stalls (optional), or reaches stop_acc accepts
    task automatic stream(input int p_valid, input bit auto_wait, input bit stop_on_stall,
                          input int stop_acc, input int max_cycles);
        int n;
        n = 0;
        while (n < max_cycles && !bus_if.img_done &&
               !(stop_on_stall && n > 0 && !bus_if.in_ready) &&
               !(stop_acc >= 0 && dut_acc >= stop_acc)) begin
            bus_if.in_valid       = ($urandom_range(99) < p_valid);
            bus_if.in_data        = PIX_W'($urandom);
            bus_if.ld_row_to_wait = 1'b0;
            if (auto_wait && m_active && m_wr_row() > m_wait + ROWS - 1) begin
                bus_if.ld_row_to_wait = 1'b1;
                bus_if.row_to_wait    = 10'(m_wr_row() - (ROWS - 1));
            end else if (auto_wait && $urandom_range(9) == 0) begin
                bus_if.ld_row_to_wait = 1'b1;
                bus_if.row_to_wait    = 10'($urandom_range(m_wait));
            end
            cycle();
            n++;
        end
        bus_if.in_valid       = 1'b0;
        bus_if.ld_row_to_wait = 1'b0;
        check("stream_bound", 32'(n < max_cycles), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.start = 0; bus_if.src_w = 0; bus_if.src_h = 0;
        bus_if.in_valid = 0; bus_if.in_data = 0;
        bus_if.ld_row_to_wait = 0; bus_if.row_to_wait = 0;
        bus_if.rd_row = 0; bus_if.rd_col = 0;
        model_reset();

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        RESETN = 1'b1;
        cycle();

        // 4x3, continuous valid, wait 0: buffer_done after pixel 8, img_done after 12
        start_image(4, 3);
        stream(100, 1'b0, 1'b0, -1, 50);
        check("img_4x3_accepts", 32'(dut_acc), 32'd12);
        cycle();

        // 8x10, wait 0: stall at first pixel of row 4, release with ld_row_to_wait 1
        start_image(8, 10);
        stream(100, 1'b0, 1'b1, -1, 100);
        check("stall_point", 32'(dut_acc), 32'd32);
        bus_if.in_valid = 1'b1;
        cycle();
        bus_if.ld_row_to_wait = 1'b1;
        bus_if.row_to_wait    = 10'd1;
        cycle();
        bus_if.ld_row_to_wait = 1'b0;
        cycle();
        cycle();
        stream(80, 1'b1, 1'b0, -1, 600);

        // single-row image: need clamps to row 0
        start_image(5, 1);
        bus_if.ld_row_to_wait = 1'b1;
        bus_if.row_to_wait    = 10'd0;
        cycle();
        stream(60, 1'b0, 1'b0, -1, 100);
        cycle();

        // ld_row_to_wait 5 while writing row 3: buffer_done low until row 6 completes
        start_image(8, 10);
        stream(100, 1'b0, 1'b0, 24, 100);
        bus_if.ld_row_to_wait = 1'b1;
        bus_if.row_to_wait    = 10'd5;
        bus_if.in_valid       = 1'b1;
        cycle();
        bus_if.ld_row_to_wait = 1'b0;
        check("bd_after_ld5", 32'(bus_if.buffer_done), 32'd0);
        stream(100, 1'b1, 1'b0, -1, 600);

        // known pixel at (2,3), read back one cycle later
        start_image(6, 4);
        stream(100, 1'b1, 1'b0, 15, 100);
        bus_if.in_data  = 24'hAABBCC;
        bus_if.in_valid = 1'b1;
        cycle();
        bus_if.in_valid = 1'b0;
        rd_random = 1'b0;
        bus_if.rd_row = 10'd2;
        bus_if.rd_col = 10'd3;
        cycle();
        check("rd_aabbcc", 32'(bus_if.rd_data), 32'h00AABBCC);
        rd_random = 1'b1;
        stream(70, 1'b1, 1'b0, -1, 300);

        // reset mid-row 2, then restart at (0,0)
        start_image(4, 4);
        stream(100, 1'b0, 1'b0, 9, 100);
        #2;
        RESETN = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        check("rst_buffer_done", 32'(bus_if.buffer_done), 32'd0);
        check("rst_img_done", 32'(bus_if.img_done), 32'd0);
        check("rst_rd_data", 32'(bus_if.rd_data), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        check_outputs();
        RESETN = 1'b1;
        start_image(3, 2);
        bus_if.in_data  = 24'h123456;
        bus_if.in_valid = 1'b1;
        cycle();
        bus_if.in_valid = 1'b0;
        rd_random = 1'b0;
        bus_if.rd_row = 10'd0;
        bus_if.rd_col = 10'd0;
        cycle();
        check("restart_00", 32'(bus_if.rd_data), 32'h00123456);
        rd_random = 1'b1;
        stream(70, 1'b1, 1'b0, -1, 200);

        // abort an image in flight with a new start
        start_image(5, 8);
        stream(90, 1'b1, 1'b0, 12, 100);
        start_image(3, 3);
        stream(70, 1'b1, 1'b0, -1, 200);
        check("abort_accepts", 32'(dut_acc), 32'd9);

        // random geometries
        for (int k = 0; k < 4; k++) begin
            start_image($urandom_range(8, 1), $urandom_range(12, 1));
            stream(50, 1'b1, 1'b0, -1, 2000);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
